// File: rtl/ppb_input_conditioner_if.sv
// ppb_input_conditioner_if
//
// Purpose: groups the panel-side signals of the input conditioner into one
// bundle. The conditioner uses the master modport and the mapping stage, or a
// test driver, uses the slave modport.
//
// Signals:
//   raw_inputs     [0:N_IN-1]  unsynchronised panel lines (slave -> master)
//   device_inputs  [0:N_IN-1]  conditioned levels / press pulses (master -> slave)
//   rise_pulse     [0:N_IN-1]  one-cycle strobe per debounced rising edge
//   changed        1           one-cycle strobe on any debounced level change
//
// Handshake: none. raw_inputs is sampled continuously and may change at any
// time. Every master output is a registered level or a one-cycle strobe, valid
// on every cycle, with no ready/backpressure path.
interface ppb_input_conditioner_if #(
  parameter int N_IN = 60
);
  logic [0:N_IN-1] raw_inputs;
  logic [0:N_IN-1] device_inputs;
  logic [0:N_IN-1] rise_pulse;
  logic            changed;

  modport master (
    input  raw_inputs,
    output device_inputs,
    output rise_pulse,
    output changed
  );

  modport slave (
    output raw_inputs,
    input  device_inputs,
    input  rise_pulse,
    input  changed
  );
endinterface

// File: rtl/ppb_input_conditioner.sv
// ppb_input_conditioner
//
// Purpose: synchronises and debounces the raw PPB panel switch/button lines.
// Each channel is delivered as a clean level, or, for channels set in
// PULSE_MASK, as a single-cycle pulse per debounced press.
//
// Parameters:
//   N_IN            number of panel channels
//   TICK_DIV        clock cycles per debounce tick (>= 1)
//   DEBOUNCE_TICKS  consecutive mismatching ticks needed to accept a level (>= 1)
//   PULSE_MASK      bit i set puts channel i in pulse mode (default: channel 1)
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   io       ppb_input_conditioner_if.master
//            (raw_inputs in; device_inputs, rise_pulse, changed out)
//
// All outputs are registered and have no combinational path from raw_inputs.
module ppb_input_conditioner #(
  parameter int              N_IN           = 60,
  parameter int              TICK_DIV       = 100000,
  parameter int              DEBOUNCE_TICKS = 10,
  parameter logic [0:N_IN-1] PULSE_MASK     = {1'b0, 1'b1, {(N_IN-2){1'b0}}}
) (
  input  logic clk,
  input  logic reset_n,
  ppb_input_conditioner_if.master io
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [0:N_IN-1] sync1;
  logic [0:N_IN-1] s;
  logic [PW-1:0]   p;
  logic            tick;
  logic [0:N_IN-1] lvl;
  logic [0:N_IN-1] lvl_q;
  logic [CW-1:0]   cnt [N_IN];
  logic [0:N_IN-1] rise_q;
  logic [0:N_IN-1] dev_q;
  logic            changed_q;

  // Free-running prescaler: tick never realigns to input activity.
  assign tick = (p == P_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      s         <= '0;
      p         <= '0;
      lvl       <= '0;
      lvl_q     <= '0;
      rise_q    <= '0;
      dev_q     <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= io.raw_inputs;
      s     <= sync1;
      p     <= tick ? '0 : p + PW'(1);

      // Any cycle where the input agrees with the stable level clears the
      // count, so a commit needs an unbroken run of mismatching ticks.
      for (int i = 0; i < N_IN; i++) begin
        if (s[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == C_LAST) begin
            lvl[i] <= s[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end

      lvl_q     <= lvl;
      rise_q    <= lvl & ~lvl_q;
      changed_q <= |(lvl ^ lvl_q);
      // Level channels are registered from lvl as well, so both modes land
      // on the same cycle as rise_pulse.
      dev_q     <= (PULSE_MASK & lvl & ~lvl_q) | (~PULSE_MASK & lvl);
    end
  end

  assign io.device_inputs = dev_q;
  assign io.rise_pulse    = rise_q;
  assign io.changed       = changed_q;

endmodule

// File: tb/tb_ppb_input_conditioner.sv
// tb_ppb_input_conditioner
//
// Directed bench for ppb_input_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge (or on the falling edge in the monitoring loops).
// Latency is counted in rising edges after the edge that first samples a
// raw change, so a debounced change lands 11..14 edges later.
module tb_ppb_input_conditioner;

  localparam int N_IN = 60;
  localparam int TD   = 4;
  localparam int DT   = 3;

  logic clk;
  logic reset_n;

  int tests = 0;
  int fails = 0;

  ppb_input_conditioner_if #(.N_IN(N_IN)) io ();

  ppb_input_conditioner #(
    .N_IN           (N_IN),
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call right after driving at a falling edge. Returns the number of rising
  // edges after the sampling edge until device_inputs[ch] == val, or -1.
  task automatic wait_dev(input int ch, input logic val, input int budget, output int lat);
    lat = -1;
    @(posedge clk);
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (io.device_inputs[ch] === val) begin
        lat = n;
        break;
      end
    end
  endtask

  function automatic logic in_win(input int lat);
    return (lat >= 11 && lat <= 14);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int pulses, rises, chg, first0, first5;
    logic act;
    int maxc;
    logic found;

    reset_n = 1'b0;
    io.raw_inputs = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_device", io.device_inputs, '0);
    check("reset_rise", io.rise_pulse, '0);
    check("reset_changed", io.changed, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) step();

    // ---- clean press on channel 0 ----
    @(negedge clk);
    io.raw_inputs[0] = 1'b1;
    wait_dev(0, 1'b1, 40, lat);
    check("press_latency_window", in_win(lat), 1'b1);
    check("press_rise_aligned", io.rise_pulse[0], 1'b1);
    check("press_changed_aligned", io.changed, 1'b1);
    step();
    check("press_rise_one_cycle", io.rise_pulse[0], 1'b0);
    check("press_changed_one_cycle", io.changed, 1'b0);
    check("press_level_held", io.device_inputs[0], 1'b1);
    repeat (40) step();
    check("press_level_still_held", io.device_inputs[0], 1'b1);

    // release: level channel falls, changed strobes, no rise
    @(negedge clk);
    io.raw_inputs[0] = 1'b0;
    wait_dev(0, 1'b0, 40, lat);
    check("release_latency_window", in_win(lat), 1'b1);
    check("release_changed", io.changed, 1'b1);
    check("release_no_rise", io.rise_pulse[0], 1'b0);
    repeat (5) step();

    // ---- glitch of 6 cycles on channel 0 ----
    act  = 1'b0;
    maxc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      act |= io.device_inputs[0] | io.rise_pulse[0] | io.changed;
      if (int'(dut.cnt[0]) > maxc) maxc = int'(dut.cnt[0]);
      io.raw_inputs[0] = (n < 6);
    end
    check("glitch_no_activity", act, 1'b0);
    check("glitch_count_max2", (maxc <= 2), 1'b1);

    // ---- pulse mode on channel 1 ----
    pulses = 0; rises = 0; chg = 0; first0 = -1;
    @(negedge clk);
    io.raw_inputs[1] = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (io.device_inputs[1]) begin
        pulses++;
        if (first0 < 0) first0 = n;
      end
      rises += int'(io.rise_pulse[1]);
      chg   += int'(io.changed);
    end
    check("pulse_latency_window", in_win(first0 - 1), 1'b1);
    check("pulse_single_cycle", pulses, 1);
    check("pulse_rise_count", rises, 1);
    check("pulse_press_changed", chg, 1);

    pulses = 0; rises = 0; chg = 0;
    @(negedge clk);
    io.raw_inputs[1] = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      step();
      pulses += int'(io.device_inputs[1]);
      rises  += int'(io.rise_pulse[1]);
      chg    += int'(io.changed);
    end
    check("pulse_no_release_pulse", pulses, 0);
    check("pulse_release_no_rise", rises, 0);
    check("pulse_release_changed", chg, 1);

    // ---- simultaneous change on channels 0 and 5 ----
    first0 = -1; first5 = -1; chg = 0;
    @(negedge clk);
    io.raw_inputs[0] = 1'b1;
    io.raw_inputs[5] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (io.device_inputs[0] && first0 < 0) first0 = n;
      if (io.device_inputs[5] && first5 < 0) first5 = n;
      chg += int'(io.changed);
    end
    check("simul_latency_window", in_win(first0 - 1), 1'b1);
    check("simul_same_cycle", first5, first0);
    check("simul_single_changed", chg, 1);

    // ---- reset while C[2] == 2 ----
    @(negedge clk);
    io.raw_inputs[2] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (dut.cnt[2] == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reached_count2", found, 1'b1);
    check("rst_pre_levels", {io.device_inputs[0], io.device_inputs[5]}, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_device", io.device_inputs, '0);
    check("rst_async_rise", io.rise_pulse, '0);
    check("rst_async_changed", io.changed, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // p restarts at 0: s mismatches after edge 2, ticks land on edges 4, 8
    // and 12 (commit), output on edge 13, which is 12 edges after edge 1.
    wait_dev(2, 1'b1, 40, lat);
    check("rst_recommit_latency", lat, 12);
    check("rst_recommit_levels", {io.device_inputs[0], io.device_inputs[1],
                                  io.device_inputs[2], io.device_inputs[5]}, 4'b1011);
    check("rst_recommit_rises", {io.rise_pulse[0], io.rise_pulse[2], io.rise_pulse[5]}, 3'b111);
    check("rst_recommit_changed", io.changed, 1'b1);
    repeat (5) step();

    // ---- bounce train on channel 3 ----
    act = 1'b0;
    for (int n = 0; n < 42; n++) begin
      @(negedge clk);
      act |= io.device_inputs[3] | io.rise_pulse[3] | io.changed;
      io.raw_inputs[3] = (((n / 3) % 2) == 0);
    end
    @(negedge clk);
    act |= io.device_inputs[3] | io.rise_pulse[3] | io.changed;
    io.raw_inputs[3] = 1'b1;
    wait_dev(3, 1'b1, 40, lat);
    check("bounce_quiet", act, 1'b0);
    check("bounce_latency_window", in_win(lat), 1'b1);
    check("bounce_rise", io.rise_pulse[3], 1'b1);
    step();
    check("bounce_level_held", io.device_inputs[3], 1'b1);
    check("bounce_rise_one_cycle", io.rise_pulse[3], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
